// File: rtl/uart_reg_slave.sv
// uart_reg_slave: register bank behind the UART transaction master.
// Accepts held OCP-style commands, posts writes and returns single-cycle read responses.
// Ports:
//   clk, reset_n                   clock, synchronous active-low reset
//   uart_MCmd/MAddr/MData          command (001 WR, 010 RD), byte address, write data
//   uart_SCmdAccept                one-cycle accept pulse
//   uart_SResp/SData               read response (01 DVA, 11 ERR) and data
//   gpio_in                        status inputs, readable at 0x12/0x13
//   reg_out                        RW registers, reg[n] on bits [8n+7:8n]
//   wr_strobe                      one-hot pulse the cycle after RW reg n is written
module uart_reg_slave #(
    parameter int unsigned ACCEPT_WAIT = 0,
    parameter int unsigned RD_LATENCY  = 0,
    parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  uart_MCmd,
    input  logic [7:0]  uart_MAddr,
    input  logic [7:0]  uart_MData,
    output logic        uart_SCmdAccept,
    output logic [7:0]  uart_SData,
    output logic [1:0]  uart_SResp,
    input  logic [15:0] gpio_in,
    output logic [63:0] reg_out,
    output logic [7:0]  wr_strobe
);

    localparam logic [2:0] CMD_WR = 3'b001;
    localparam logic [2:0] CMD_RD = 3'b010;

    localparam logic [3:0] AW_LAST = 4'(ACCEPT_WAIT - 1);
    localparam logic [3:0] RL_LAST = 4'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCEPT,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic             is_rd_q, is_rd_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0][7:0]  regs_q, regs_d;
    logic [1:0]       status_q, status_d;
    logic [7:0]       cmdcnt_q, cmdcnt_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             rerr_q, rerr_d;
    logic [7:0]       wr_strobe_q, wr_strobe_d;

    // Address decode of the latched command address
    logic       a_rw;
    logic       a_id;
    logic       a_st;
    logic       a_g0;
    logic       a_g1;
    logic       a_cc;
    logic       rd_hit;
    logic       wr_ok;
    logic [7:0] rd_mux;
    logic [1:0] st_clr;
    logic [1:0] err_set;

    always_comb begin
        a_rw   = (addr_q[7:3] == 5'd0);
        a_id   = (addr_q == 8'h10);
        a_st   = (addr_q == 8'h11);
        a_g0   = (addr_q == 8'h12);
        a_g1   = (addr_q == 8'h13);
        a_cc   = (addr_q == 8'h14);
        rd_hit = a_rw | a_id | a_st | a_g0 | a_g1 | a_cc;
        wr_ok  = a_rw | a_st | a_cc;
    end

    // Read data as it will be snapshotted at the accept edge; CMDCNT
    // already includes the reading command itself.
    always_comb begin
        rd_mux = 8'h00;
        if (a_rw) rd_mux = regs_q[addr_q[2:0]];
        if (a_id) rd_mux = ID_VALUE;
        if (a_st) rd_mux = {6'd0, status_q};
        if (a_g0) rd_mux = gpio_in[7:0];
        if (a_g1) rd_mux = gpio_in[15:8];
        if (a_cc) rd_mux = cmdcnt_q + 8'd1;
    end

    always_comb begin
        state_d     = state_q;
        is_rd_d     = is_rd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        regs_d      = regs_q;
        cmdcnt_d    = cmdcnt_q;
        rdata_d     = rdata_q;
        rerr_d      = rerr_q;
        wr_strobe_d = 8'h00;
        st_clr      = 2'b00;
        err_set     = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (uart_MCmd == CMD_WR || uart_MCmd == CMD_RD) begin
                    is_rd_d = (uart_MCmd == CMD_RD);
                    addr_d  = uart_MAddr;
                    data_d  = uart_MData;
                    cnt_d   = 4'd0;
                    state_d = (ACCEPT_WAIT > 0) ? S_WAIT : S_ACCEPT;
                end
            end
            S_WAIT: begin
                if (cnt_q == AW_LAST) begin
                    state_d = S_ACCEPT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACCEPT: begin
                cmdcnt_d = cmdcnt_q + 8'd1;
                cnt_d    = 4'd0;
                if (is_rd_q) begin
                    rdata_d    = rd_mux;
                    rerr_d     = !rd_hit;
                    err_set[1] = !rd_hit;
                    state_d    = (RD_LATENCY > 0) ? S_RD_WAIT : S_RESP;
                end else begin
                    if (wr_ok) begin
                        if (a_rw) begin
                            regs_d[addr_q[2:0]] = data_q;
                            wr_strobe_d = 8'h01 << addr_q[2:0];
                        end
                        if (a_st) st_clr = data_q[1:0];
                        // Clearing beats this command's own increment
                        if (a_cc) cmdcnt_d = 8'h00;
                    end else begin
                        err_set[0] = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == RL_LAST) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Sticky flags: a new error on a bit wins over its W1C
        status_d = (status_q & ~st_clr) | err_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            is_rd_q     <= 1'b0;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            cnt_q       <= 4'd0;
            regs_q      <= '0;
            status_q    <= 2'b00;
            cmdcnt_q    <= 8'h00;
            rdata_q     <= 8'h00;
            rerr_q      <= 1'b0;
            wr_strobe_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            is_rd_q     <= is_rd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            regs_q      <= regs_d;
            status_q    <= status_d;
            cmdcnt_q    <= cmdcnt_d;
            rdata_q     <= rdata_d;
            rerr_q      <= rerr_d;
            wr_strobe_q <= wr_strobe_d;
        end
    end

    always_comb begin
        uart_SCmdAccept = (state_q == S_ACCEPT);
        uart_SResp      = 2'b00;
        uart_SData      = 8'h00;
        if (state_q == S_RESP) begin
            uart_SResp = rerr_q ? 2'b11 : 2'b01;
            uart_SData = rerr_q ? 8'h00 : rdata_q;
        end
    end

    assign reg_out   = regs_q;
    assign wr_strobe = wr_strobe_q;

endmodule

// File: tb/tb_uart_reg_slave.sv
// tb_uart_reg_slave: directed bench for uart_reg_slave.
// dut0 uses default timing, dut1 uses ACCEPT_WAIT=3, RD_LATENCY=2.
module tb_uart_reg_slave;

    localparam logic [2:0] WR = 3'b001;
    localparam logic [2:0] RD = 3'b010;

    logic        clk;
    logic        reset_n;

    logic [2:0]  m0_cmd, m1_cmd;
    logic [7:0]  m0_addr, m1_addr;
    logic [7:0]  m0_data, m1_data;
    logic        acc0, acc1;
    logic [7:0]  sd0, sd1;
    logic [1:0]  sr0, sr1;
    logic [15:0] gp0, gp1;
    logic [63:0] ro0, ro1;
    logic [7:0]  ws0, ws1;

    logic        sel;
    logic        o_acc;
    logic [7:0]  o_sd;
    logic [1:0]  o_sr;
    logic [7:0]  o_ws;

    int checks;
    int errors;

    int         r_acc_cyc;
    int         r_acc_cnt;
    int         r_resp_cyc;
    int         r_resp_cnt;
    logic [1:0] r_resp;
    logic [7:0] r_data;
    logic [7:0] r_ws;
    int         r_ws_cnt;
    int         n_acc;
    int         n_resp;

    uart_reg_slave dut0 (
        .clk             (clk),
        .reset_n         (reset_n),
        .uart_MCmd       (m0_cmd),
        .uart_MAddr      (m0_addr),
        .uart_MData      (m0_data),
        .uart_SCmdAccept (acc0),
        .uart_SData      (sd0),
        .uart_SResp      (sr0),
        .gpio_in         (gp0),
        .reg_out         (ro0),
        .wr_strobe       (ws0)
    );

    uart_reg_slave #(
        .ACCEPT_WAIT (3),
        .RD_LATENCY  (2)
    ) dut1 (
        .clk             (clk),
        .reset_n         (reset_n),
        .uart_MCmd       (m1_cmd),
        .uart_MAddr      (m1_addr),
        .uart_MData      (m1_data),
        .uart_SCmdAccept (acc1),
        .uart_SData      (sd1),
        .uart_SResp      (sr1),
        .gpio_in         (gp1),
        .reg_out         (ro1),
        .wr_strobe       (ws1)
    );

    assign o_acc = sel ? acc1 : acc0;
    assign o_sd  = sel ? sd1 : sd0;
    assign o_sr  = sel ? sr1 : sr0;
    assign o_ws  = sel ? ws1 : ws0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [7:0] a,
                         input logic [7:0] d);
        if (sel) begin
            m1_cmd = c; m1_addr = a; m1_data = d;
        end else begin
            m0_cmd = c; m0_addr = a; m0_data = d;
        end
    endtask

    // Present a command, watch a fixed window of cycles; cycle 0 is the
    // cycle in which the command is first visible to the DUT.
    task automatic run_cmd(input logic [2:0] c, input logic [7:0] a,
                           input logic [7:0] d, input int ncyc);
        @(posedge clk); #1;
        drive(c, a, d);
        r_acc_cyc  = -1;
        r_acc_cnt  = 0;
        r_resp_cyc = -1;
        r_resp_cnt = 0;
        r_resp     = 2'b00;
        r_data     = 8'h00;
        r_ws       = 8'h00;
        r_ws_cnt   = 0;
        for (int i = 1; i <= ncyc; i++) begin
            @(posedge clk); #1;
            if (o_acc) begin
                if (r_acc_cnt == 0) r_acc_cyc = i;
                r_acc_cnt++;
                drive(3'b000, 8'hEE, 8'h00);
            end
            if (o_sr != 2'b00) begin
                if (r_resp_cnt == 0) begin
                    r_resp_cyc = i;
                    r_resp     = o_sr;
                    r_data     = o_sd;
                end
                r_resp_cnt++;
            end
            if (o_ws != 8'h00) begin
                r_ws = r_ws | o_ws;
                r_ws_cnt++;
            end
        end
        drive(3'b000, 8'h00, 8'h00);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        sel     = 1'b0;
        reset_n = 1'b0;
        m0_cmd = 3'b000; m0_addr = 8'h00; m0_data = 8'h00;
        m1_cmd = 3'b000; m1_addr = 8'h00; m1_data = 8'h00;
        gp0 = 16'hBEEF;
        gp1 = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_accept", {63'd0, acc0}, 64'd0);
        chk("rst_sresp", {62'd0, sr0}, 64'd0);
        chk("rst_sdata", {56'd0, sd0}, 64'd0);
        chk("rst_regout", ro0, 64'd0);
        chk("rst_wstrobe", {56'd0, ws0}, 64'd0);
        reset_n = 1'b1;

        // 1: ID read timing
        run_cmd(RD, 8'h10, 8'h00, 8);
        chk("t1_acc_cyc", 64'(r_acc_cyc), 64'd1);
        chk("t1_acc_cnt", 64'(r_acc_cnt), 64'd1);
        chk("t1_resp_cyc", 64'(r_resp_cyc), 64'd2);
        chk("t1_resp_cnt", 64'(r_resp_cnt), 64'd1);
        chk("t1_resp", {62'd0, r_resp}, 64'd1);
        chk("t1_data", {56'd0, r_data}, 64'hA5);

        // 2: RW write and readback
        run_cmd(WR, 8'h03, 8'h5C, 8);
        chk("t2_wr_acc", 64'(r_acc_cyc), 64'd1);
        chk("t2_wr_noresp", 64'(r_resp_cnt), 64'd0);
        chk("t2_ws_val", {56'd0, r_ws}, 64'h08);
        chk("t2_ws_cnt", 64'(r_ws_cnt), 64'd1);
        chk("t2_regout", ro0, 64'h00000000_5C000000);
        run_cmd(RD, 8'h03, 8'h00, 8);
        chk("t2_rd_data", {56'd0, r_data}, 64'h5C);

        // 3: stretched timing on dut1
        sel = 1'b1;
        run_cmd(RD, 8'h12, 8'h00, 12);
        chk("t3_acc_cyc", 64'(r_acc_cyc), 64'd4);
        chk("t3_resp_cyc", 64'(r_resp_cyc), 64'd7);
        chk("t3_resp_cnt", 64'(r_resp_cnt), 64'd1);
        chk("t3_data", {56'd0, r_data}, 64'h34);
        run_cmd(RD, 8'h13, 8'h00, 12);
        chk("t3_data_hi", {56'd0, r_data}, 64'h12);
        run_cmd(WR, 8'h05, 8'h77, 12);
        chk("t3_wr_acc", 64'(r_acc_cyc), 64'd4);
        chk("t3_regout", ro1, 64'h00007700_00000000);
        sel = 1'b0;

        // 4: errors and sticky status
        run_cmd(RD, 8'h20, 8'h00, 8);
        chk("t4_err_resp", {62'd0, r_resp}, 64'd3);
        chk("t4_err_data", {56'd0, r_data}, 64'h00);
        run_cmd(WR, 8'h10, 8'hFF, 8);
        chk("t4_ro_noresp", 64'(r_resp_cnt), 64'd0);
        chk("t4_ro_nows", 64'(r_ws_cnt), 64'd0);
        run_cmd(RD, 8'h11, 8'h00, 8);
        chk("t4_status3", {56'd0, r_data}, 64'h03);
        run_cmd(WR, 8'h11, 8'h01, 8);
        run_cmd(RD, 8'h11, 8'h00, 8);
        chk("t4_status2", {56'd0, r_data}, 64'h02);
        run_cmd(RD, 8'h12, 8'h00, 8);
        chk("t4_gpio_lo", {56'd0, r_data}, 64'hEF);

        // 5: command counter wrap and clear
        run_cmd(WR, 8'h14, 8'h00, 4);
        for (int k = 0; k < 255; k++) begin
            run_cmd(RD, 8'h10, 8'h00, 4);
        end
        run_cmd(RD, 8'h14, 8'h00, 4);
        chk("t5_wrap", {56'd0, r_data}, 64'h00);
        run_cmd(WR, 8'h14, 8'h42, 4);
        run_cmd(RD, 8'h14, 8'h00, 4);
        chk("t5_clear", {56'd0, r_data}, 64'h01);

        // 6: reset during WAIT on dut1, then an illegal command code
        sel   = 1'b1;
        n_acc = 0;
        n_resp = 0;
        @(posedge clk); #1;
        drive(WR, 8'h06, 8'h11);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (acc1) n_acc++;
            if (sr1 != 2'b00) n_resp++;
        end
        reset_n = 1'b0;
        drive(3'b000, 8'h00, 8'h00);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (acc1) n_acc++;
            if (sr1 != 2'b00) n_resp++;
        end
        chk("t6_no_acc", 64'(n_acc), 64'd0);
        chk("t6_no_resp", 64'(n_resp), 64'd0);
        chk("t6_regs0", ro1, 64'd0);
        sel = 1'b0;
        run_cmd(3'b011, 8'h03, 8'h99, 10);
        chk("t6_bad_acc", 64'(r_acc_cnt), 64'd0);
        chk("t6_bad_resp", 64'(r_resp_cnt), 64'd0);
        chk("t6_bad_regs", ro0, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
